demux32_1to8_reg: RTL

//  Registered 1-to-8 demultiplexer for 32-bit datapath words. It is the write-side

---
 rtl/demux32_1to8_reg.sv | 98 +++++++++
 1 files changed

// File: rtl/demux32_1to8_reg.sv
// rtl/demux32_1to8_reg.sv - registered 1-to-8 word demux with per-lane valid/ack holding registers
// Optional AUTO_SEL_EN: destination comes from an internal round-robin write pointer instead of inSel.
module demux32_1to8_reg #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] inData,
  input  logic [SEL_W-1:0] inSel,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic [WIDTH-1:0] outC,
  output logic [WIDTH-1:0] outD,
  output logic [WIDTH-1:0] outE,
  output logic [WIDTH-1:0] outF,
  output logic [WIDTH-1:0] outG,
  output logic [WIDTH-1:0] outH,
  output logic [7:0]       outValid,
  input  logic [7:0]       outAck,
  output logic [3:0]       count,
  output logic [SEL_W-1:0] wrPtr
);

  localparam int LANES = 8;

  logic [WIDTH-1:0] lane_q [LANES];
  logic [WIDTH-1:0] lane_d [LANES];
  logic [LANES-1:0] valid_q, valid_d;
  logic [3:0]       count_q, count_d;
  logic [SEL_W-1:0] dest;
  logic             wr_en;

`ifdef AUTO_SEL_EN
  logic [SEL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             unused_sel;

  assign unused_sel = ^inSel;
  assign dest       = wr_ptr_q;
  assign wrPtr      = wr_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + SEL_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) wr_ptr_q <= '0;
    else       wr_ptr_q <= wr_ptr_d;
  end
`else
  assign dest  = inSel;
  assign wrPtr = '0;
`endif

  // An ack on the destination lane frees it in the same cycle, so a write can replace the word.
  assign inReady = ~valid_q[dest] | outAck[dest];
  assign wr_en   = inValid & inReady;

  always_comb begin
    lane_d  = lane_q;
    valid_d = valid_q & ~outAck;
    if (wr_en) begin
      lane_d[dest]  = inData;
      valid_d[dest] = 1'b1;
    end
    count_d = '0;
    for (int i = 0; i < LANES; i++) begin
      count_d = count_d + {3'b000, valid_d[i]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lane_q  <= '{default: '0};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      lane_q  <= lane_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign outA     = lane_q[0];
  assign outB     = lane_q[1];
  assign outC     = lane_q[2];
  assign outD     = lane_q[3];
  assign outE     = lane_q[4];
  assign outF     = lane_q[5];
  assign outG     = lane_q[6];
  assign outH     = lane_q[7];
  assign outValid = valid_q;
  assign count    = count_q;

endmodule
